// File: rtl/single_led_decoder_if.sv
// Signal bundle between a serial LED data line driver and the decoder.
// The decoder side takes the slave modport; the line driver / consumer side takes master.
interface single_led_decoder_if;
  logic        DI;
  logic [23:0] data;
  logic        data_valid;
  logic        frame_reset;
  logic [15:0] word_count;
  logic        bit_error;
  logic        busy;

  modport master (
    output DI,
    input  data, data_valid, frame_reset, word_count, bit_error, busy
  );

  modport slave (
    input  DI,
    output data, data_valid, frame_reset, word_count, bit_error, busy
  );
endinterface

// File: rtl/single_led_decoder.sv
// Decodes a single-wire LED data stream into 24-bit words by timing high pulses,
// with frame-reset gap detection and illegal-pulse / truncated-word reporting.
module single_led_decoder #(
  parameter int T1_THRESH  = 30,
  parameter int T_MIN_HIGH = 5,
  parameter int T_MAX_HIGH = 55,
  parameter int T_RESET    = 2500
) (
  input  logic                 clk,
  input  logic                 reset,
  single_led_decoder_if.slave  led
);
  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  localparam logic [12:0] T1_W    = 13'(T1_THRESH);
  localparam logic [12:0] TMIN_W  = 13'(T_MIN_HIGH);
  localparam logic [12:0] TMAX_W  = 13'(T_MAX_HIGH);
  localparam logic [12:0] TRST_W  = 13'(T_RESET);

  state_t      state_q, state_d;
  logic        di_meta_q, di_sync_q;
  logic [11:0] cnt_q, cnt_d;
  logic [12:0] dur;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [22:0] shift_q, shift_d;
  logic [23:0] data_q, data_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic        data_valid_q, data_valid_d;
  logic        frame_reset_q, frame_reset_d;
  logic        bit_error_q, bit_error_d;
  logic        new_bit;

  // dur counts the current cycle too, so it equals the completed length of the
  // level that put us in this state (entry happens one cycle after the edge).
  assign dur     = {1'b0, cnt_q} + 13'd1;
  assign new_bit = (dur >= T1_W);

  always_ff @(posedge clk) begin
    if (reset) begin
      di_meta_q     <= 1'b0;
      di_sync_q     <= 1'b0;
      state_q       <= SYNC;
      cnt_q         <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      word_cnt_q    <= '0;
      data_valid_q  <= 1'b0;
      frame_reset_q <= 1'b0;
      bit_error_q   <= 1'b0;
    end else begin
      di_meta_q     <= led.DI;
      di_sync_q     <= di_meta_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      data_q        <= data_d;
      word_cnt_q    <= word_cnt_d;
      data_valid_q  <= data_valid_d;
      frame_reset_q <= frame_reset_d;
      bit_error_q   <= bit_error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = (cnt_q == 12'hFFF) ? cnt_q : cnt_q + 12'd1;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    data_d        = data_q;
    word_cnt_d    = word_cnt_q;
    data_valid_d  = 1'b0;
    frame_reset_d = 1'b0;
    bit_error_d   = 1'b0;
    case (state_q)
      SYNC: begin
        if (di_sync_q) begin
          cnt_d = '0;
        end else if (dur >= TRST_W) begin
          frame_reset_d = 1'b1;
          word_cnt_d    = '0;
          bit_cnt_d     = '0;
          state_d       = IDLE;
          cnt_d         = '0;
        end
      end
      IDLE: begin
        if (di_sync_q) begin
          state_d = HIGH;
          cnt_d   = '0;
        end
      end
      HIGH: begin
        if (dur >= TMAX_W || (!di_sync_q && dur < TMIN_W)) begin
          bit_error_d = 1'b1;
          bit_cnt_d   = '0;
          state_d     = SYNC;
          cnt_d       = '0;
        end else if (!di_sync_q) begin
          // Right shift so the first bit received lands in data[0].
          shift_d = {new_bit, shift_q[22:1]};
          if (bit_cnt_q == 5'd23) begin
            data_d       = {new_bit, shift_q};
            data_valid_d = 1'b1;
            bit_cnt_d    = '0;
            if (word_cnt_q != 16'hFFFF) begin
              word_cnt_d = word_cnt_q + 16'd1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
          state_d = LOW;
          cnt_d   = '0;
        end
      end
      LOW: begin
        if (dur >= TRST_W) begin
          frame_reset_d = 1'b1;
          bit_error_d   = (bit_cnt_q != 5'd0);
          word_cnt_d    = '0;
          bit_cnt_d     = '0;
          state_d       = IDLE;
          cnt_d         = '0;
        end else if (di_sync_q) begin
          state_d = HIGH;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = SYNC;
        cnt_d   = '0;
      end
    endcase
  end

  assign led.data        = data_q;
  assign led.data_valid  = data_valid_q;
  assign led.frame_reset = frame_reset_q;
  assign led.word_count  = word_cnt_q;
  assign led.bit_error   = bit_error_q;
  assign led.busy        = (state_q == HIGH) || (state_q == LOW && bit_cnt_q != 5'd0);
endmodule

// File: tb/tb_single_led_decoder.sv
// Bench for single_led_decoder: directed pulse trains, a run-length reference model
// checked every cycle, and literal expectations per scenario.
module tb_single_led_decoder;
  localparam int T1   = 30;
  localparam int TMIN = 5;
  localparam int TMAX = 55;
  localparam int TRST = 2500;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  single_led_decoder_if led();

  single_led_decoder #(
    .T1_THRESH (T1),
    .T_MIN_HIGH(TMIN),
    .T_MAX_HIGH(TMAX),
    .T_RESET   (TRST)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .led  (led)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: line as seen through two flops, run lengths of that line.
  bit          m_meta, m_sync, m_live;
  bit          locked, in_pulse, gap_timed;
  int          lo_run, hi_done, lo_done, nbits, m_wc;
  logic [23:0] word_acc, m_data;
  bit          e_dv, e_fr, e_be;

  int          cyc = 0;
  int          dv_cnt, fr_cnt, be_cnt, both_cnt, fr_cyc, be_cyc;
  logic [23:0] dv_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic fault();
    e_be     = 1'b1;
    locked   = 1'b0;
    in_pulse = 1'b0;
    lo_run   = 0;
    nbits    = 0;
  endtask

  task automatic model_step(input logic rst, input logic di);
    bit s;
    e_dv = 1'b0;
    e_fr = 1'b0;
    e_be = 1'b0;
    if (rst) begin
      m_meta = 1'b0; m_sync = 1'b0; m_live = 1'b1;
      locked = 1'b0; in_pulse = 1'b0; gap_timed = 1'b0;
      lo_run = 0; hi_done = 0; lo_done = 0; nbits = 0; m_wc = 0;
      m_data = '0;
    end else begin
      s      = m_sync;
      m_sync = m_meta;
      m_meta = di;
      if (!locked) begin
        if (s) lo_run = 0;
        else begin
          lo_run++;
          if (lo_run >= TRST) begin
            e_fr = 1'b1; locked = 1'b1; gap_timed = 1'b0; m_wc = 0; nbits = 0;
          end
        end
      end else if (in_pulse) begin
        // hi_done = high cycles completed before this one
        if (hi_done >= TMAX) fault();
        else if (!s) begin
          if (hi_done < TMIN) fault();
          else begin
            word_acc[nbits] = (hi_done >= T1);
            nbits++;
            if (nbits == 24) begin
              m_data = word_acc; e_dv = 1'b1; nbits = 0;
              if (m_wc < 65535) m_wc++;
            end
            in_pulse = 1'b0; gap_timed = 1'b1; lo_done = 1;
          end
        end else hi_done++;
      end else begin
        if (gap_timed && lo_done >= TRST) begin
          e_fr = 1'b1; e_be = (nbits != 0); nbits = 0; m_wc = 0; gap_timed = 1'b0;
        end else if (s) begin
          in_pulse = 1'b1; hi_done = 1;
        end else if (gap_timed) lo_done++;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      model_step(reset, led.DI);
      #1;
      if (m_live) begin
        chk("data",        32'(led.data),        32'(m_data));
        chk("data_valid",  32'(led.data_valid),  32'(e_dv));
        chk("frame_reset", 32'(led.frame_reset), 32'(e_fr));
        chk("word_count",  32'(led.word_count),  32'(m_wc));
        chk("bit_error",   32'(led.bit_error),   32'(e_be));
        chk("busy",        32'(led.busy),        32'(in_pulse || nbits != 0));
        if (led.data_valid) begin dv_cnt++; dv_q.push_back(led.data); end
        if (led.frame_reset) begin fr_cnt++; fr_cyc = cyc; end
        if (led.bit_error) begin be_cnt++; be_cyc = cyc; end
        if (led.frame_reset && led.bit_error) both_cnt++;
      end
    end
  end

  task automatic drive(input logic v, input int n);
    led.DI = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    if (b) begin drive(1'b1, 40); drive(1'b0, 21); end
    else   begin drive(1'b1, 20); drive(1'b0, 41); end
  endtask

  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[i]);
  endtask

  task automatic clear_counts();
    dv_cnt = 0; fr_cnt = 0; be_cnt = 0; both_cnt = 0; fr_cyc = 0; be_cyc = 0;
    dv_q.delete();
  endtask

  initial begin
    int rel_cyc, hs;
    led.DI = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(led.data), 0);
    chk("rst_word_count", 32'(led.word_count), 0);
    chk("rst_busy", 32'(led.busy), 0);
    chk("rst_pulses", 32'({led.data_valid, led.frame_reset, led.bit_error}), 0);

    // Sync-up gap straight out of reset.
    clear_counts();
    reset   = 1'b0;
    rel_cyc = cyc;
    drive(1'b0, 2600);
    chk("s1_frame_reset_count", 32'(fr_cnt), 1);
    // Cleared synchronizer flops already read low, so the 2500th edge after
    // release is expected; a couple of cycles of slack covers input latency.
    chk("s1_frame_reset_latency", 32'((fr_cyc - rel_cyc) >= 2500 && (fr_cyc - rel_cyc) <= 2502), 1);
    chk("s1_data", 32'(led.data), 0);
    chk("s1_word_count", 32'(led.word_count), 0);

    // One word.
    clear_counts();
    send_bits(24'h5A3C96, 24);
    drive(1'b0, 50);
    chk("s2_dv_count", 32'(dv_cnt), 1);
    chk("s2_data", 32'(led.data), 32'h005A3C96);
    chk("s2_model_data", 32'(m_data), 32'h005A3C96);
    chk("s2_word_count", 32'(led.word_count), 1);
    chk("s2_bit_error_count", 32'(be_cnt), 0);

    // Two words then a frame gap.
    clear_counts();
    send_bits(24'hFFFFFF, 24);
    send_bits(24'h000001, 24);
    drive(1'b0, 2600);
    chk("s3_dv_count", 32'(dv_cnt), 2);
    chk("s3_word0", 32'(dv_q[0]), 32'h00FFFFFF);
    chk("s3_word1", 32'(dv_q[1]), 32'h00000001);
    chk("s3_frame_reset_count", 32'(fr_cnt), 1);
    chk("s3_word_count", 32'(led.word_count), 0);
    chk("s3_bit_error_count", 32'(be_cnt), 0);

    // Short glitch mid-word drops to resync.
    clear_counts();
    send_bits(24'h0F0F0F, 5);
    drive(1'b1, 3);
    drive(1'b0, 50);
    chk("s4_glitch_bit_error", 32'(be_cnt), 1);
    chk("s4_busy_after_glitch", 32'(led.busy), 0);
    send_bits(24'hFFFFFF, 3);
    drive(1'b0, 2600);
    chk("s4_no_dv_while_unsynced", 32'(dv_cnt), 0);
    chk("s4_frame_reset_count", 32'(fr_cnt), 1);
    send_bits(24'hA5A5A5, 24);
    drive(1'b0, 50);
    chk("s4_dv_count", 32'(dv_cnt), 1);
    chk("s4_data", 32'(led.data), 32'h00A5A5A5);
    chk("s4_model_data", 32'(m_data), 32'h00A5A5A5);
    chk("s4_word_count", 32'(led.word_count), 1);

    // Overlong high, then truncated word ended by a frame gap.
    clear_counts();
    hs = cyc;
    drive(1'b1, 60);
    // 55 high cycles, plus 2 synchronizer stages, plus the output register.
    chk("s5_maxhigh_latency", 32'(be_cyc - hs), 58);
    chk("s5_maxhigh_bit_error", 32'(be_cnt), 1);
    drive(1'b0, 2600);
    chk("s5_resync_frame_reset", 32'(fr_cnt), 1);
    send_bits(24'h0003FF, 10);
    drive(1'b0, 2600);
    chk("s5_frame_reset_count", 32'(fr_cnt), 2);
    chk("s5_bit_error_count", 32'(be_cnt), 2);
    chk("s5_fr_be_same_cycle", 32'(both_cnt), 1);
    chk("s5_data_unchanged", 32'(led.data), 32'h00A5A5A5);
    chk("s5_dv_count", 32'(dv_cnt), 0);
    chk("s5_word_count", 32'(led.word_count), 0);

    // Reset mid-word.
    clear_counts();
    send_bits(24'hABCDEF, 12);
    chk("s6_busy_mid_word", 32'(led.busy), 1);
    reset = 1'b1;
    @(posedge clk);
    #2;
    chk("s6_rst_data", 32'(led.data), 0);
    chk("s6_rst_word_count", 32'(led.word_count), 0);
    chk("s6_rst_busy", 32'(led.busy), 0);
    chk("s6_rst_pulses", 32'({led.data_valid, led.frame_reset, led.bit_error}), 0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 2600);
    chk("s6_no_bit_error", 32'(be_cnt), 0);
    chk("s6_frame_reset_count", 32'(fr_cnt), 1);
    send_bits(24'h123456, 24);
    drive(1'b0, 50);
    chk("s6_dv_count", 32'(dv_cnt), 1);
    chk("s6_data", 32'(led.data), 32'h00123456);
    chk("s6_model_data", 32'(m_data), 32'h00123456);
    chk("s6_word_count", 32'(led.word_count), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
